// File: rtl/vga_sync_gen.sv
// 640x480@60 raster timing generator: pixel/line counters, registered syncs, visible flag and strobes.
// Optional VGA_BLINK_EN adds a 5-bit frame counter whose MSB drives blink; otherwise blink is 0.
module vga_sync_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       clk25mhz,
    input  logic       reset,
    input  logic       enable,
    output logic [9:0] hindex,
    output logic [9:0] vindex,
    output logic       hsync,
    output logic       vsync,
    output logic       visible,
    output logic       line_start,
    output logic       frame_start,
    output logic       blink
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [9:0] hindex_q, hindex_d;
    logic [9:0] vindex_q, vindex_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       visible_q, visible_d;
    logic       line_start_q, line_start_d;
    logic       frame_start_q, frame_start_d;
    logic       h_wrap, v_wrap;

    assign h_wrap = (hindex_q == H_LAST);
    assign v_wrap = (vindex_q == V_LAST);

    // Decodes use the next counter values so every output lines up with the index it accompanies.
    always_comb begin
        hindex_d      = hindex_q;
        vindex_d      = vindex_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        visible_d     = visible_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        if (enable) begin
            hindex_d      = h_wrap ? 10'd0 : hindex_q + 10'd1;
            vindex_d      = h_wrap ? (v_wrap ? 10'd0 : vindex_q + 10'd1) : vindex_q;
            hsync_d       = !((hindex_d >= HS_START) && (hindex_d < HS_END));
            vsync_d       = !((vindex_d >= VS_START) && (vindex_d < VS_END));
            visible_d     = (hindex_d < H_VIS) && (vindex_d < V_VIS);
            line_start_d  = h_wrap;
            frame_start_d = h_wrap && v_wrap;
        end
    end

    always_ff @(posedge clk25mhz or posedge reset) begin
        if (reset) begin
            hindex_q      <= 10'd0;
            vindex_q      <= 10'd0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            visible_q     <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hindex_q      <= hindex_d;
            vindex_q      <= vindex_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            visible_q     <= visible_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

`ifdef VGA_BLINK_EN
    logic [4:0] frame_cnt_q, frame_cnt_d;

    // Counts on the same edge that raises frame_start, so blink flips with the 16th strobe.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (frame_start_d) frame_cnt_d = frame_cnt_q + 5'd1;
    end

    always_ff @(posedge clk25mhz or posedge reset) begin
        if (reset) frame_cnt_q <= 5'd0;
        else       frame_cnt_q <= frame_cnt_d;
    end

    assign blink = frame_cnt_q[4];
`else
    assign blink = 1'b0;
`endif

    assign hindex      = hindex_q;
    assign vindex      = vindex_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign visible     = visible_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a default-width instance with a short frame, plus a tiny instance for blink.
module tb_vga_sync_gen;

    localparam int M_HV = 640, M_HF = 16, M_HS = 96, M_HB = 48;
    localparam int M_VV = 12, M_VF = 3, M_VS = 2, M_VB = 4;
    localparam int M_HT = 800, M_FT = 800 * 21;
    localparam int S_HV = 8, S_HF = 2, S_HS = 3, S_HB = 2;
    localparam int S_VV = 4, S_VF = 1, S_VS = 2, S_VB = 1;
    localparam int S_FT = 15 * 8;
    localparam logic [25:0] RST_VEC = {10'd0, 10'd0, 6'b110000};
`ifdef VGA_BLINK_EN
    localparam logic BLINK_ON = 1'b1;
`else
    localparam logic BLINK_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset, m_en, s_en;
    logic [9:0] m_hindex, m_vindex, s_hindex, s_vindex;
    logic m_hsync, m_vsync, m_visible, m_ls, m_fs, m_blink;
    logic s_hsync, s_vsync, s_visible, s_ls, s_fs, s_blink;
    logic [25:0] m_act, s_act;

    int vectors = 0, miscompares = 0;
    int m_pos = 0, s_pos = 0;
    bit m_last = 0, s_last = 0;

    always #20 clk = ~clk;

    vga_sync_gen #(.H_VISIBLE(M_HV), .H_FRONT(M_HF), .H_SYNC(M_HS), .H_BACK(M_HB),
                   .V_VISIBLE(M_VV), .V_FRONT(M_VF), .V_SYNC(M_VS), .V_BACK(M_VB)) u_main (
        .clk25mhz(clk), .reset(reset), .enable(m_en), .hindex(m_hindex), .vindex(m_vindex),
        .hsync(m_hsync), .vsync(m_vsync), .visible(m_visible), .line_start(m_ls),
        .frame_start(m_fs), .blink(m_blink));

    vga_sync_gen #(.H_VISIBLE(S_HV), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
                   .V_VISIBLE(S_VV), .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB)) u_small (
        .clk25mhz(clk), .reset(reset), .enable(s_en), .hindex(s_hindex), .vindex(s_vindex),
        .hsync(s_hsync), .vsync(s_vsync), .visible(s_visible), .line_start(s_ls),
        .frame_start(s_fs), .blink(s_blink));

    assign m_act = {m_hindex, m_vindex, m_hsync, m_vsync, m_visible, m_ls, m_fs, m_blink};
    assign s_act = {s_hindex, s_vindex, s_hsync, s_vsync, s_visible, s_ls, s_fs, s_blink};

    // Reference: outputs follow from how many enabled edges have elapsed since reset.
    function automatic logic [25:0] ref_out(int pos, bit last_en, int hv, int hf, int hs, int hb,
                                            int vv, int vf, int vs, int vb);
        int ht = hv + hf + hs + hb;
        int vt = vv + vf + vs + vb;
        int h, v, frames;
        logic hs_n, vs_n, vis, ls, fs, bl;
        if (pos == 0) return RST_VEC;
        h = pos % ht;
        v = (pos / ht) % vt;
        frames = pos / (ht * vt);
        hs_n = !(h >= hv + hf && h < hv + hf + hs);
        vs_n = !(v >= vv + vf && v < vv + vf + vs);
        vis  = (h < hv) && (v < vv);
        ls   = last_en && (h == 0);
        fs   = ls && (v == 0);
        bl   = BLINK_ON && ((frames % 32) >= 16);
        return {10'(h), 10'(v), hs_n, vs_n, vis, ls, fs, bl};
    endfunction

    function automatic logic [25:0] m_exp();
        return ref_out(m_pos, m_last, M_HV, M_HF, M_HS, M_HB, M_VV, M_VF, M_VS, M_VB);
    endfunction

    function automatic logic [25:0] s_exp();
        return ref_out(s_pos, s_last, S_HV, S_HF, S_HS, S_HB, S_VV, S_VF, S_VS, S_VB);
    endfunction

    task automatic step(input bit me, input bit se);
        m_en = me;
        s_en = se;
        @(posedge clk);
        if (me) m_pos++;
        m_last = me;
        if (se) s_pos++;
        s_last = se;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; m_en = 1'b0; s_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (m_act !== RST_VEC) begin miscompares++; $display("FAIL reset_main got %h exp %h", m_act, RST_VEC); end
        vectors++;
        if (s_act !== RST_VEC) begin miscompares++; $display("FAIL reset_small got %h exp %h", s_act, RST_VEC); end
        reset = 1'b0;
        step(1, 0);
        vectors++;
        if (m_act !== m_exp()) begin miscompares++; $display("FAIL first_edge got %h exp %h", m_act, m_exp()); end
        vectors++;
        if (m_hindex !== 10'd1 || m_vindex !== 10'd0 || m_visible !== 1'b1 || m_hsync !== 1'b1 || m_ls !== 1'b0) begin
            miscompares++; $display("FAIL first_edge_fields got h=%0d v=%0d vis=%b hs=%b ls=%b exp h=1 v=0 vis=1 hs=1 ls=0",
                                    m_hindex, m_vindex, m_visible, m_hsync, m_ls);
        end
    endtask

    task automatic test_line();
        while (m_pos < M_HT + 4) begin
            step(1, 0);
            vectors++;
            if (m_act !== m_exp()) begin miscompares++; $display("FAIL line pos=%0d got %h exp %h", m_pos, m_act, m_exp()); end
            if (m_pos == M_HT) begin
                vectors++;
                if (m_ls !== 1'b1 || m_hindex !== 10'd0 || m_vindex !== 10'd1) begin
                    miscompares++; $display("FAIL line_start got ls=%b h=%0d v=%0d exp ls=1 h=0 v=1", m_ls, m_hindex, m_vindex);
                end
            end
        end
    endtask

    task automatic test_vsync();
        while (m_pos < (M_VV + M_VF + M_VS + 1) * M_HT) begin
            step(1, 0);
            vectors++;
            if (m_act !== m_exp()) begin miscompares++; $display("FAIL vsync pos=%0d got %h exp %h", m_pos, m_act, m_exp()); end
        end
    endtask

    task automatic test_frame_wrap();
        while (m_pos < M_FT + 3) begin
            step(1, 0);
            vectors++;
            if (m_act !== m_exp()) begin miscompares++; $display("FAIL frame pos=%0d got %h exp %h", m_pos, m_act, m_exp()); end
            if (m_pos == M_FT) begin
                vectors++;
                if (m_act !== {20'd0, 6'b111110}) begin
                    miscompares++; $display("FAIL frame_wrap got %h exp %h", m_act, {20'd0, 6'b111110});
                end
            end
        end
    endtask

    task automatic test_enable_hold();
        logic [25:0] saved;
        while (m_pos % M_HT != 655) begin
            step(1, 0);
            vectors++;
            if (m_act !== m_exp()) begin miscompares++; $display("FAIL pre_hold pos=%0d got %h exp %h", m_pos, m_act, m_exp()); end
        end
        saved = m_act;
        repeat (10) begin
            step(0, 0);
            vectors++;
            if (m_act !== saved || m_act !== m_exp()) begin
                miscompares++; $display("FAIL hold got %h exp %h", m_act, m_exp());
            end
        end
        step(1, 0);
        vectors++;
        if (m_hindex !== 10'd656 || m_hsync !== 1'b0 || m_act !== m_exp()) begin
            miscompares++; $display("FAIL reenable got %h exp %h", m_act, m_exp());
        end
    endtask

    task automatic test_reset_mid();
        while (m_pos % M_FT != 2 * M_HT + 300) begin
            step(1, 0);
            vectors++;
            if (m_act !== m_exp()) begin miscompares++; $display("FAIL pre_reset pos=%0d got %h exp %h", m_pos, m_act, m_exp()); end
        end
        #5 reset = 1'b1;
        #1;
        vectors++;
        if (m_act !== RST_VEC) begin miscompares++; $display("FAIL async_reset got %h exp %h", m_act, RST_VEC); end
        @(posedge clk);
        #3 reset = 1'b0;
        m_pos = 0; s_pos = 0; m_last = 0; s_last = 0;
        step(0, 0);
        vectors++;
        if (m_act !== RST_VEC || s_act !== RST_VEC) begin
            miscompares++; $display("FAIL reset_release got %h/%h exp %h", m_act, s_act, RST_VEC);
        end
        step(1, 0);
        vectors++;
        if (m_act !== m_exp()) begin miscompares++; $display("FAIL post_reset got %h exp %h", m_act, m_exp()); end
    endtask

    task automatic test_blink();
        while (s_pos < 33 * S_FT + 5) begin
            step(0, 1);
            vectors++;
            if (s_act !== s_exp()) begin miscompares++; $display("FAIL blink_run pos=%0d got %h exp %h", s_pos, s_act, s_exp()); end
            if (s_pos == 16 * S_FT - 1 || s_pos == 32 * S_FT + 1) begin
                vectors++;
                if (s_blink !== 1'b0) begin miscompares++; $display("FAIL blink_low pos=%0d got %b exp 0", s_pos, s_blink); end
            end
            if (s_pos == 16 * S_FT + 1) begin
                vectors++;
                if (s_blink !== BLINK_ON) begin miscompares++; $display("FAIL blink_high got %b exp %b", s_blink, BLINK_ON); end
            end
        end
    endtask

    task automatic test_random();
        repeat (3000) begin
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
            vectors++;
            if (m_act !== m_exp()) begin miscompares++; $display("FAIL rand_main pos=%0d got %h exp %h", m_pos, m_act, m_exp()); end
            vectors++;
            if (s_act !== s_exp()) begin miscompares++; $display("FAIL rand_small pos=%0d got %h exp %h", s_pos, s_act, s_exp()); end
        end
    endtask

    initial begin
        test_reset();
        test_line();
        test_vsync();
        test_frame_wrap();
        test_enable_hold();
        test_reset_mid();
        test_blink();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
